inst_fetch_queue: RTL and testbench

//   Fetch stage of the RV64I core, immediately upstream of decode/immediate extension.

---
 rtl/inst_fetch_queue.sv | 129 ++++++++++++
 tb/tb_inst_fetch_queue.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - RV64I fetch stage: PC, in-order fetch queue, redirect flush
module inst_fetch_queue #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [63:0] id_pc
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    // Extra bit so back-to-back redirects with responses still outstanding cannot wrap.
    localparam int DW = CW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [63:0]      pc_q, pc_d;
    logic             run_q;
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [PW-1:0]    fptr_q, fptr_d;
    logic [CW-1:0]    alloc_cnt_q, alloc_cnt_d;
    logic [CW-1:0]    fill_cnt_q, fill_cnt_d;
    logic [DW-1:0]    drop_cnt_q, drop_cnt_d;
    logic [DEPTH-1:0] filled_q, filled_d;
    logic [63:0]      ent_pc_q   [DEPTH];
    logic [31:0]      ent_inst_q [DEPTH];

    logic             req_fire;
    logic             pop;
    logic             fill;
    logic [CW-1:0]    unfilled;

    assign imem_req_valid = run_q && (alloc_cnt_q < CW'(DEPTH)) && !redirect_valid;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign id_valid = filled_q[head_q];
    assign id_inst  = id_valid ? ent_inst_q[head_q] : NOP;
    assign id_pc    = id_valid ? ent_pc_q[head_q] : 64'h0;

    assign pop      = id_valid && id_ready && !redirect_valid;
    assign fill     = imem_rsp_valid && (drop_cnt_q == '0) && !redirect_valid;
    assign unfilled = alloc_cnt_q - fill_cnt_q;

    always_comb begin
        pc_d        = pc_q;
        head_d      = head_q;
        tail_d      = tail_q;
        fptr_d      = fptr_q;
        alloc_cnt_d = alloc_cnt_q;
        fill_cnt_d  = fill_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        filled_d    = filled_q;
        if (redirect_valid) begin
            pc_d        = {redirect_pc[63:2], 2'b00};
            head_d      = '0;
            tail_d      = '0;
            fptr_d      = '0;
            alloc_cnt_d = '0;
            fill_cnt_d  = '0;
            filled_d    = '0;
            // A response landing now consumes either a pending drop or one unfilled slot.
            drop_cnt_d  = drop_cnt_q + DW'(unfilled) - DW'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                pc_d             = pc_q + 64'd4;
                tail_d           = tail_q + PW'(1);
                filled_d[tail_q] = 1'b0;
            end
            if (imem_rsp_valid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - DW'(1);
            end
            if (fill) begin
                filled_d[fptr_q] = 1'b1;
                fptr_d           = fptr_q + PW'(1);
            end
            if (pop) begin
                filled_d[head_q] = 1'b0;
                head_d           = head_q + PW'(1);
            end
            alloc_cnt_d = alloc_cnt_q + CW'(req_fire) - CW'(pop);
            fill_cnt_d  = fill_cnt_q + CW'(fill) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            run_q       <= 1'b0;
            head_q      <= '0;
            tail_q      <= '0;
            fptr_q      <= '0;
            alloc_cnt_q <= '0;
            fill_cnt_q  <= '0;
            drop_cnt_q  <= '0;
            filled_q    <= '0;
        end else begin
            pc_q        <= pc_d;
            run_q       <= 1'b1;
            head_q      <= head_d;
            tail_q      <= tail_d;
            fptr_q      <= fptr_d;
            alloc_cnt_q <= alloc_cnt_d;
            fill_cnt_q  <= fill_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            filled_q    <= filled_d;
        end
    end

    // Payload storage needs no reset: it is only visible through filled_q.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            ent_pc_q[tail_q] <= pc_q;
        end
        if (fill) begin
            ent_inst_q[fptr_q] <= imem_rsp_data;
        end
    end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - directed bench for inst_fetch_queue
module tb_inst_fetch_queue;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        id_valid;
    logic        id_ready = 1'b1;
    logic [31:0] id_inst;
    logic [63:0] id_pc;

    int          checks = 0;
    int          errors = 0;
    int          acc_cnt = 0;
    logic [63:0] last_acc = 64'h0;
    logic        mem_hold = 1'b0;
    logic [63:0] pend [$];

    inst_fetch_queue dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_inst        (id_inst),
        .id_pc          (id_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [63:0] a);
        return a[31:0] ^ 32'hC0DE_0000;
    endfunction

    // In-order memory: records accepts before the edge, answers one cycle later.
    always begin
        @(negedge clk);
        if (rst_n && imem_req_valid && imem_req_ready) begin
            pend.push_back(imem_req_addr);
            acc_cnt++;
            last_acc = imem_req_addr;
        end
        if (rst_n && imem_rsp_valid)
            assert (dut.drop_cnt_q != 0 || dut.alloc_cnt_q != dut.fill_cnt_q)
            else $error("FAIL rsp_target: response with no unfilled entry");
        @(posedge clk);
        #2;
        if (!rst_n) begin
            pend.delete();
            imem_rsp_valid = 1'b0;
        end else if (!mem_hold && pend.size() > 0) begin
            imem_rsp_data  = word_of(pend.pop_front());
            imem_rsp_valid = 1'b1;
        end else begin
            imem_rsp_valid = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!imem_req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!imem_req_valid) begin
            errors++;
            $display("FAIL req_timeout: imem_req_valid=%b expected 1", imem_req_valid);
        end
    endtask

    task automatic wait_id();
        int n = 0;
        while (!id_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!id_valid) begin
            errors++;
            $display("FAIL id_timeout: id_valid=%b expected 1", id_valid);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid);
        end
        checks++;
        if (id_valid !== 1'b0) begin
            errors++; $display("FAIL reset_id_valid: got %b expected 0", id_valid);
        end
        checks++;
        if (id_inst !== NOP) begin
            errors++; $display("FAIL reset_id_inst: got %h expected %h", id_inst, NOP);
        end
        checks++;
        if (id_pc !== 64'h0) begin
            errors++; $display("FAIL reset_id_pc: got %h expected 0", id_pc);
        end
        checks++;
        if (imem_req_addr !== 64'h0) begin
            errors++; $display("FAIL reset_addr: got %h expected 0", imem_req_addr);
        end
    endtask

    task automatic test_stream();
        tick();
        rst_n = 1'b1;
        wait_req();
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (imem_req_addr !== 64'(4 * k)) begin
                errors++; $display("FAIL stream_addr%0d: got %h expected %h", k, imem_req_addr, 64'(4 * k));
            end
        end
        wait_id();
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (id_valid !== 1'b1 || id_pc !== 64'(4 * k) || id_inst !== word_of(64'(4 * k))) begin
                errors++; $display("FAIL stream_id%0d: got v=%b pc=%h inst=%h expected pc=%h", k, id_valid, id_pc, id_inst, 64'(4 * k));
            end
        end
    endtask

    task automatic test_backpressure();
        int a0;
        tick();
        rst_n = 1'b0;
        id_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        a0 = acc_cnt;
        repeat (12) @(negedge clk);
        checks++;
        if (acc_cnt - a0 != 4) begin
            errors++; $display("FAIL bp_accepts: got %0d expected 4", acc_cnt - a0);
        end
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++; $display("FAIL bp_req_valid: got %b expected 0", imem_req_valid);
        end
        tick();
        id_ready = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (id_valid !== 1'b1 || id_pc !== 64'(4 * k) || id_inst !== word_of(64'(4 * k))) begin
                errors++; $display("FAIL bp_drain%0d: got v=%b pc=%h expected pc=%h", k, id_valid, id_pc, 64'(4 * k));
            end
        end
    endtask

    task automatic test_req_stall();
        logic [63:0] a0;
        int          c0;
        tick();
        imem_req_ready = 1'b0;
        @(negedge clk);
        a0 = imem_req_addr;
        c0 = acc_cnt;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== a0) begin
                errors++; $display("FAIL stall_hold%0d: got v=%b addr=%h expected addr=%h", k, imem_req_valid, imem_req_addr, a0);
            end
        end
        tick();
        checks++;
        if (acc_cnt != c0) begin
            errors++; $display("FAIL stall_no_accept: got %0d accepts expected %0d", acc_cnt, c0);
        end
        imem_req_ready = 1'b1;
        tick();
        checks++;
        if (acc_cnt != c0 + 1 || last_acc !== a0) begin
            errors++; $display("FAIL stall_resume: got n=%0d addr=%h expected n=%0d addr=%h", acc_cnt, last_acc, c0 + 1, a0);
        end
        @(negedge clk);
        checks++;
        if (imem_req_addr !== a0 + 64'd4) begin
            errors++; $display("FAIL stall_next: got %h expected %h", imem_req_addr, a0 + 64'd4);
        end
    endtask

    task automatic test_redirect();
        int a0;
        tick();
        rst_n = 1'b0;
        imem_req_ready = 1'b0;
        mem_hold = 1'b1;
        tick();
        rst_n = 1'b1;
        wait_req();
        tick();
        a0 = acc_cnt;
        imem_req_ready = 1'b1;
        tick();
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 64'h1002;
        checks++;
        if (acc_cnt - a0 != 2) begin
            errors++; $display("FAIL redir_inflight: got %0d expected 2", acc_cnt - a0);
        end
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++; $display("FAIL redir_no_req: got %b expected 0", imem_req_valid);
        end
        tick();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        mem_hold = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h1000) begin
            errors++; $display("FAIL redir_addr: got v=%b addr=%h expected 1000", imem_req_valid, imem_req_addr);
        end
        wait_id();
        checks++;
        if (id_pc !== 64'h1000 || id_inst !== word_of(64'h1000)) begin
            errors++; $display("FAIL redir_first_id: got pc=%h inst=%h expected pc=1000", id_pc, id_inst);
        end
    endtask

    task automatic test_redirect_collide();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (id_valid !== 1'b1) begin
            errors++; $display("FAIL coll_pre_id: got %b expected 1", id_valid);
        end
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 64'h2003;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (id_valid !== 1'b0 || id_pc !== 64'h0 || id_inst !== NOP) begin
            errors++; $display("FAIL coll_id_cleared: got v=%b pc=%h inst=%h expected 0/0/%h", id_valid, id_pc, id_inst, NOP);
        end
        checks++;
        if (dut.alloc_cnt_q !== 0 || dut.drop_cnt_q !== 0) begin
            errors++; $display("FAIL coll_counts: got alloc=%0d drop=%0d expected 0/0", dut.alloc_cnt_q, dut.drop_cnt_q);
        end
        checks++;
        if (imem_req_addr !== 64'h2000) begin
            errors++; $display("FAIL coll_addr: got %h expected 2000", imem_req_addr);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 64'h2000 || id_inst !== word_of(64'h2000)) begin
            errors++; $display("FAIL coll_first_id: got v=%b pc=%h expected pc=2000", id_valid, id_pc);
        end
    endtask

    task automatic test_reset_mid();
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || id_valid !== 1'b0) begin
            errors++; $display("FAIL mid_valids: got req=%b id=%b expected 0/0", imem_req_valid, id_valid);
        end
        checks++;
        if (id_inst !== NOP || id_pc !== 64'h0 || imem_req_addr !== 64'h0) begin
            errors++; $display("FAIL mid_fields: got inst=%h pc=%h addr=%h expected %h/0/0", id_inst, id_pc, imem_req_addr, NOP);
        end
        tick();
        rst_n = 1'b1;
        wait_req();
        checks++;
        if (imem_req_addr !== 64'h0) begin
            errors++; $display("FAIL mid_restart_addr: got %h expected 0", imem_req_addr);
        end
        wait_id();
        checks++;
        if (id_pc !== 64'h0 || id_inst !== word_of(64'h0)) begin
            errors++; $display("FAIL mid_restart_id: got pc=%h inst=%h expected pc=0", id_pc, id_inst);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_req_stall();
        test_redirect();
        test_redirect_collide();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
